frame_timing_ctrl: RTL and testbench
====================================

FRAME_TIMING_CTRL -- requirements
Module: frame_timing_ctrl

Interface
REQ-001 Parameter LINE_MAX, default 100, SHALL set the number of pixels per line.
REQ-002 Parameter FRAME_MAX, default 50, SHALL set the number of lines per frame.
REQ-003 Parameter HBLANK, default 8, SHALL set the pix_en ticks between lines.
REQ-004 Parameter VBLANK, default 16, SHALL set the pix_en ticks before the first line of a frame.
REQ-005 Parameter PKT_WORDS, default 512, SHALL set the pixels per package.
REQ-006 Port sys_clk, input, 1 bit, SHALL be the single clock; reset is synchronous and active-low.
REQ-007 Port sys_rst_n, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-008 Port pix_en, input, 1 bit, SHALL be a pixel-rate enable pulse.
REQ-009 Port start, input, 1 bit, SHALL request capture start.
REQ-010 Port stop, input, 1 bit, SHALL request capture stop.
REQ-011 Port pixel_in, input, 8 bits, SHALL carry the data_in7..0 source bits.
REQ-012 Port rd_out, input, 1 bit, SHALL signal that the package read is complete.
REQ-013 Port frame_valid, output, 1 bit, SHALL indicate that a frame is active.
REQ-014 Port line_valid, output, 1 bit, SHALL indicate that a line is active.
REQ-015 Port pixel_out, output, 8 bits, SHALL carry the captured pixel.
REQ-016 Port pixel_we, output, 1 bit, SHALL strobe each captured pixel.
REQ-017 Port package_ready, output, 1 bit, SHALL pulse when a package is complete.
REQ-018 Port cs_n, output, 1 bit, SHALL be the active-low readout select.
REQ-019 Port frame_cnt, output, 16 bits, SHALL count completed frames.
REQ-020 Port busy, output, 1 bit, SHALL indicate that the block is not in IDLE.
REQ-021 Port overrun, output, 1 bit, SHALL be a sticky package-overrun flag.

Function
REQ-022 The FSM SHALL have states IDLE, VBLANK, ACTIVE, HBLANK and FRAME_END.
REQ-023 IDLE: on start, the FSM SHALL go to VBLANK and clear the pixel, line and blank counters.
REQ-024 VBLANK: after VBLANK pix_en ticks, the FSM SHALL go to ACTIVE with line=0.
REQ-025 ACTIVE: on the pix_en that makes pix = LINE_MAX-1, the FSM SHALL go to FRAME_END if line = FRAME_MAX-1, otherwise to HBLANK.
REQ-026 HBLANK: after HBLANK pix_en ticks, the FSM SHALL go to ACTIVE and increment line.
REQ-027 FRAME_END lasts one sys_clk cycle: it SHALL increment frame_cnt (wrapping at 0xFFFF to 0), then go to IDLE if stop is pending, otherwise to VBLANK.
REQ-028 frame_valid SHALL be 1 in ACTIVE and HBLANK; line_valid SHALL be 1 in ACTIVE only; both SHALL be decoded from the registered state with zero additional latency.
REQ-029 In ACTIVE, each pix_en SHALL register pixel_in into pixel_out and assert pixel_we for exactly one cycle, on the next cycle.
REQ-030 A stop received while busy SHALL be latched and applied only at FRAME_END, so frames are never truncated; stop SHALL be ignored in IDLE.
REQ-031 start SHALL be ignored while busy; if start and stop arrive together in IDLE, start SHALL win and stop SHALL be dropped.
REQ-032 A word counter SHALL count pixel_we; on the pixel_we that makes it PKT_WORDS-1, it SHALL wrap to 0 and pulse package_ready for one cycle on the next cycle.
REQ-033 cs_n SHALL go to 0 the cycle after package_ready and return to 1 the cycle after rd_out.
REQ-034 If package_ready and rd_out occur in the same cycle, package_ready SHALL win and cs_n SHALL stay 0.
REQ-035 A package_ready while cs_n=0 SHALL set overrun; overrun SHALL clear only on an accepted start or on reset.
REQ-036 The word counter SHALL persist across frames and SHALL clear only on an accepted start.

Reset
REQ-037 While sys_rst_n=0 at a sys_clk edge: state SHALL be IDLE; all counters 0; frame_valid, line_valid, pixel_we, package_ready, busy and overrun SHALL be 0; pixel_out SHALL be 0x00; cs_n SHALL be 1.
REQ-038 Reset asserted mid-frame SHALL abort the frame immediately with no FRAME_END and no frame_cnt increment.

Structure
REQ-039 Shared package ftc_pkg SHALL hold the state enumeration, the default parameter values and the counter width constants.
REQ-040 The package handshake (word counter, package_ready, cs_n, overrun) SHALL be a sub-module named pkt_handshake.

Verification
All scenarios use LINE_MAX=4, FRAME_MAX=3, HBLANK=2, VBLANK=2, PKT_WORDS=6, and pix_en=1 every cycle unless stated otherwise.
REQ-041 start pulse -> frame_valid high for 16 cycles, line_valid high in three 4-cycle runs separated by 2-cycle gaps, frame_cnt=1 after 19 cycles.
REQ-042 stop asserted during line 1 -> the frame completes, frame_cnt=1, the FSM returns to IDLE and busy=0.
REQ-043 No rd_out -> package_ready after pixel 6, cs_n=0, then package_ready after pixel 12 sets overrun=1.
REQ-044 rd_out in the same cycle as the second package_ready -> cs_n stays 0.
REQ-045 pix_en every third cycle -> pixel_we count=12 per frame and pixel_out matches pixel_in at the sampled pix_en.
REQ-046 Reset asserted mid-ACTIVE -> all outputs at reset values next cycle, frame_cnt unchanged.

Source files
------------

// File: rtl/ftc_pkg.sv
// Shared types and constants for the frame timing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ftc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VBLANK    = 3'd1,
        ST_ACTIVE    = 3'd2,
        ST_HBLANK    = 3'd3,
        ST_FRAME_END = 3'd4
    } ftc_state_e;

    localparam int LINE_MAX_DEF  = 100;
    localparam int FRAME_MAX_DEF = 50;
    localparam int HBLANK_DEF    = 8;
    localparam int VBLANK_DEF    = 16;
    localparam int PKT_WORDS_DEF = 512;

    localparam int PIX_CNT_W   = 16;
    localparam int LINE_CNT_W  = 16;
    localparam int BLANK_CNT_W = 16;
    localparam int WORD_CNT_W  = 16;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/pkt_handshake.sv
// Package handshake: counts captured pixels, flags full packages, drives readout select and overrun.
// Latency: package_ready one cycle after the closing pixel_we; cs_n one cycle after package_ready / rd_out.
// Backpressure: none; a package completing while the previous one is still selected sets sticky overrun.
module pkt_handshake
    import ftc_pkg::*;
#(
    parameter int PKT_WORDS = PKT_WORDS_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic pixel_we,
    input  logic rd_out,
    output logic package_ready,
    output logic cs_n,
    output logic overrun
);

    localparam logic [WORD_CNT_W-1:0] WORD_LAST = WORD_CNT_W'(PKT_WORDS - 1);

    logic [WORD_CNT_W-1:0] word_cnt;

    // Word counter persists across frames; only an accepted start (or reset) rewinds it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            word_cnt      <= '0;
            package_ready <= 1'b0;
            cs_n          <= 1'b1;
            overrun       <= 1'b0;
        end else begin
            package_ready <= 1'b0;
            if (clr) begin
                word_cnt <= '0;
            end else if (pixel_we) begin
                if (word_cnt == WORD_LAST) begin
                    word_cnt      <= '0;
                    package_ready <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + WORD_CNT_W'(1);
                end
            end
            // A new package outranks a simultaneous read completion: select stays low.
            if (package_ready) begin
                cs_n <= 1'b0;
            end else if (rd_out) begin
                cs_n <= 1'b1;
            end
            if (clr) begin
                overrun <= 1'b0;
            end else if (package_ready && !cs_n) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_timing_ctrl.sv
// Frame timing controller: sequences VBLANK/ACTIVE/HBLANK per frame and captures the pixel stream.
// Latency: frame_valid/line_valid decode state directly; pixel_out/pixel_we one cycle after pix_en.
// Backpressure: none; the pixel stream cannot stall, late readouts are reported through overrun.
module frame_timing_ctrl
    import ftc_pkg::*;
#(
    parameter int LINE_MAX  = LINE_MAX_DEF,
    parameter int FRAME_MAX = FRAME_MAX_DEF,
    parameter int HBLANK    = HBLANK_DEF,
    parameter int VBLANK    = VBLANK_DEF,
    parameter int PKT_WORDS = PKT_WORDS_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   pix_en,
    input  logic                   start,
    input  logic                   stop,
    input  logic [7:0]             pixel_in,
    input  logic                   rd_out,
    output logic                   frame_valid,
    output logic                   line_valid,
    output logic [7:0]             pixel_out,
    output logic                   pixel_we,
    output logic                   package_ready,
    output logic                   cs_n,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [PIX_CNT_W-1:0]   PIX_LAST  = PIX_CNT_W'(LINE_MAX - 1);
    localparam logic [LINE_CNT_W-1:0]  LINE_LAST = LINE_CNT_W'(FRAME_MAX - 1);
    localparam logic [BLANK_CNT_W-1:0] HBLK_LAST = BLANK_CNT_W'(HBLANK - 1);
    localparam logic [BLANK_CNT_W-1:0] VBLK_LAST = BLANK_CNT_W'(VBLANK - 1);

    ftc_state_e             state;
    logic [PIX_CNT_W-1:0]   pix_cnt;
    logic [LINE_CNT_W-1:0]  line_cnt;
    logic [BLANK_CNT_W-1:0] blank_cnt;
    logic                   stop_pend;
    logic                   start_acc;

    assign start_acc   = (state == ST_IDLE) && start;
    assign busy        = (state != ST_IDLE);
    assign line_valid  = (state == ST_ACTIVE);
    assign frame_valid = (state == ST_ACTIVE) || (state == ST_HBLANK);

    // Frame sequencer with pixel capture; stop is only honoured at a frame boundary.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            blank_cnt <= '0;
            stop_pend <= 1'b0;
            frame_cnt <= '0;
            pixel_out <= '0;
            pixel_we  <= 1'b0;
        end else begin
            pixel_we <= 1'b0;
            if (stop && (state != ST_IDLE)) begin
                stop_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // Start wins over a coincident stop, which is simply dropped.
                    if (start) begin
                        state     <= ST_VBLANK;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                        blank_cnt <= '0;
                        stop_pend <= 1'b0;
                    end
                end
                ST_VBLANK: begin
                    if (pix_en) begin
                        if (blank_cnt == VBLK_LAST) begin
                            state     <= ST_ACTIVE;
                            blank_cnt <= '0;
                            line_cnt  <= '0;
                            pix_cnt   <= '0;
                        end else begin
                            blank_cnt <= blank_cnt + BLANK_CNT_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (pix_en) begin
                        pixel_out <= pixel_in;
                        pixel_we  <= 1'b1;
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt <= '0;
                            state   <= (line_cnt == LINE_LAST) ? ST_FRAME_END : ST_HBLANK;
                        end else begin
                            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
                        end
                    end
                end
                ST_HBLANK: begin
                    if (pix_en) begin
                        if (blank_cnt == HBLK_LAST) begin
                            state     <= ST_ACTIVE;
                            blank_cnt <= '0;
                            line_cnt  <= line_cnt + LINE_CNT_W'(1);
                        end else begin
                            blank_cnt <= blank_cnt + BLANK_CNT_W'(1);
                        end
                    end
                end
                ST_FRAME_END: begin
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                    pix_cnt   <= '0;
                    line_cnt  <= '0;
                    blank_cnt <= '0;
                    if (stop_pend || stop) begin
                        state     <= ST_IDLE;
                        stop_pend <= 1'b0;
                    end else begin
                        state <= ST_VBLANK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pkt_handshake #(
        .PKT_WORDS (PKT_WORDS)
    ) u_pkt_handshake (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .clr           (start_acc),
        .pixel_we      (pixel_we),
        .rd_out        (rd_out),
        .package_ready (package_ready),
        .cs_n          (cs_n),
        .overrun       (overrun)
    );

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// Directed bench for frame_timing_ctrl with a small 4x3 frame and 6-word packages.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: rd_out driven explicitly per scenario.
module tb_frame_timing_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        pix_en;
    logic        start;
    logic        stop;
    logic [7:0]  pixel_in;
    logic        rd_out;
    logic        frame_valid;
    logic        line_valid;
    logic [7:0]  pixel_out;
    logic        pixel_we;
    logic        package_ready;
    logic        cs_n;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    logic [21:0] fv_seen, lv_seen, we_seen, pr_seen, cs_seen, ov_seen, busy_seen;

    always #5 sys_clk = ~sys_clk;

    frame_timing_ctrl #(
        .LINE_MAX  (4),
        .FRAME_MAX (3),
        .HBLANK    (2),
        .VBLANK    (2),
        .PKT_WORDS (6)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .pix_en        (pix_en),
        .start         (start),
        .stop          (stop),
        .pixel_in      (pixel_in),
        .rd_out        (rd_out),
        .frame_valid   (frame_valid),
        .line_valid    (line_valid),
        .pixel_out     (pixel_out),
        .pixel_we      (pixel_we),
        .package_ready (package_ready),
        .cs_n          (cs_n),
        .frame_cnt     (frame_cnt),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rd_out    = 1'b0;
        pix_en    = 1'b1;
        pixel_in  = 8'h00;
        cyc();
        cyc();
        sys_rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_frame_valid"},   32'(frame_valid),   32'd0);
        check_val({pfx, "_line_valid"},    32'(line_valid),    32'd0);
        check_val({pfx, "_pixel_we"},      32'(pixel_we),      32'd0);
        check_val({pfx, "_package_ready"}, 32'(package_ready), 32'd0);
        check_val({pfx, "_busy"},          32'(busy),          32'd0);
        check_val({pfx, "_overrun"},       32'(overrun),       32'd0);
        check_val({pfx, "_pixel_out"},     32'(pixel_out),     32'h00);
        check_val({pfx, "_cs_n"},          32'(cs_n),          32'd1);
        check_val({pfx, "_frame_cnt"},     32'(frame_cnt),     32'd0);
    endtask

    initial begin
        int          we_cnt;
        logic        prev_en;
        logic [7:0]  prev_px;

        // Reset values
        do_reset();
        check_reset_outputs("rst");

        // Scenario 1: one full frame, no readout -> two packages, second one overruns
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 22; k++) begin
            fv_seen[k]   = frame_valid;
            lv_seen[k]   = line_valid;
            we_seen[k]   = pixel_we;
            pr_seen[k]   = package_ready;
            cs_seen[k]   = cs_n;
            ov_seen[k]   = overrun;
            busy_seen[k] = busy;
            if (k == 18) check_val("s1_frame_cnt_before_end", 32'(frame_cnt), 32'd0);
            if (k == 19) check_val("s1_frame_cnt_after_19", 32'(frame_cnt), 32'd1);
            pixel_in = 8'h40 + 8'(k);
            cyc();
        end
        check_val("s1_frame_valid_trace", 32'(fv_seen),   32'h23FFFC);
        check_val("s1_line_valid_trace",  32'(lv_seen),   32'h23CF3C);
        check_val("s1_pixel_we_trace",    32'(we_seen),   32'h079E78);
        check_val("s1_pkg_ready_trace",   32'(pr_seen),   32'h080800);
        check_val("s1_cs_n_trace",        32'(cs_seen),   32'h000FFF);
        check_val("s1_overrun_trace",     32'(ov_seen),   32'h300000);
        check_val("s1_busy_trace",        32'(busy_seen), 32'h3FFFFF);

        // Scenario 2: stop during line 1, rd_out coincident with second package_ready
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 23; k++) begin
            if (k == 17) check_val("s2_line2_not_truncated", 32'(line_valid), 32'd1);
            if (k == 18) check_val("s2_busy_in_frame_end", 32'(busy), 32'd1);
            if (k == 19) begin
                check_val("s2_busy_after_stop",  32'(busy),          32'd0);
                check_val("s2_frame_cnt",        32'(frame_cnt),     32'd1);
                check_val("s2_frame_valid_idle", 32'(frame_valid),   32'd0);
                check_val("s2_pkg_ready_2nd",    32'(package_ready), 32'd1);
            end
            if (k == 20) begin
                check_val("s2_cs_n_held_low", 32'(cs_n),    32'd0);
                check_val("s2_overrun_set",   32'(overrun), 32'd1);
            end
            if (k == 22) check_val("s2_cs_n_released", 32'(cs_n), 32'd1);
            stop   = (k == 9);
            rd_out = (k == 19) || (k == 21);
            cyc();
        end
        stop   = 1'b0;
        rd_out = 1'b0;

        // Scenario 3: stop ignored in IDLE, start+stop -> start wins, start ignored while busy
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_val("s3_stop_in_idle", 32'(busy), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        check_val("s3_start_wins", 32'(busy), 32'd1);
        check_val("s3_overrun_cleared", 32'(overrun), 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (k == 19) begin
                check_val("s3_frame_cnt", 32'(frame_cnt), 32'd2);
                check_val("s3_stop_dropped", 32'(busy), 32'd1);
            end
            start = (k == 5);
            cyc();
        end
        start = 1'b0;

        // Scenario 4: pix_en every third cycle
        do_reset();
        pix_en = 1'b0;
        start  = 1'b1;
        cyc();
        start   = 1'b0;
        we_cnt  = 0;
        prev_en = 1'b0;
        prev_px = 8'h00;
        for (int c = 0; c < 300 && frame_cnt == 16'd0; c++) begin
            if (pixel_we) begin
                we_cnt++;
                check_val("s4_we_follows_pix_en", 32'(prev_en), 32'd1);
                check_val("s4_pixel_out", 32'(pixel_out), 32'(prev_px));
            end
            pix_en   = ((c % 3) == 0);
            pixel_in = 8'($urandom);
            prev_en  = pix_en;
            prev_px  = pixel_in;
            cyc();
        end
        check_val("s4_frame_done", 32'(frame_cnt), 32'd1);
        check_val("s4_pixel_we_count", 32'(we_cnt), 32'd12);

        // Scenario 5: reset mid-ACTIVE aborts the frame
        do_reset();
        start = 1'b1;
        cyc();
        start    = 1'b0;
        pixel_in = 8'h5A;
        for (int i = 0; i < 20 && !line_valid; i++) cyc();
        check_val("s5_reached_active", 32'(line_valid), 32'd1);
        cyc();
        sys_rst_n = 1'b0;
        cyc();
        check_reset_outputs("s5_mid_reset");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) cyc();
        check_val("s5_stays_idle", 32'(busy), 32'd0);
        check_val("s5_no_frame_end", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
